// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - circular hardware return-address stack for the PIC-style core
//
// Purpose: CALL pushes the next program address; RETURN/RETLW pops it and
// presents it on ret_addr with a one-cycle ret_valid strobe for pcounter.
// Build option: define STACK_TRAP_EN for protective mode (full-push ignored,
// empty-pop returns zero). Undefined gives PIC16-style circular wrap.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   push       store pc_in on top of stack
//   pop        remove top entry, present it on ret_addr
//   pc_in      return address to store
//   ret_addr   registered popped address, held until next pop
//   ret_valid  one-cycle pulse after a pop
//   level      occupancy 0..DEPTH
//   overflow   sticky: push seen while full
//   underflow  sticky: pop seen while empty
module ret_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         pc_in,
    output logic [WIDTH-1:0]         ret_addr,
    output logic                     ret_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    sp;
    logic [PW-1:0]    sp_dec;
    logic             full;
    logic             empty;

    // sp points at the next free slot; the top of stack is one below it.
    assign sp_dec = sp - 1'b1;
    assign full   = (level == LW'(DEPTH));
    assign empty  = (level == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            sp        <= '0;
            level     <= '0;
            ret_addr  <= '0;
            ret_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            ret_valid <= 1'b0;
            if (push && pop) begin
                // Return and call in the same cycle: swap the top entry in place.
                ret_addr    <= mem[sp_dec];
                mem[sp_dec] <= pc_in;
                ret_valid   <= 1'b1;
            end else if (push) begin
`ifdef STACK_TRAP_EN
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    mem[sp] <= pc_in;
                    sp      <= sp + 1'b1;
                    level   <= level + 1'b1;
                end
`else
                // Full push overwrites the oldest entry and the pointer wraps.
                mem[sp] <= pc_in;
                sp      <= sp + 1'b1;
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    level <= level + 1'b1;
                end
`endif
            end else if (pop) begin
                ret_valid <= 1'b1;
`ifdef STACK_TRAP_EN
                if (empty) begin
                    ret_addr  <= '0;
                    underflow <= 1'b1;
                end else begin
                    ret_addr <= mem[sp_dec];
                    sp       <= sp_dec;
                    level    <= level - 1'b1;
                end
`else
                // Empty pop returns whatever stale entry sits below sp.
                ret_addr <= mem[sp_dec];
                sp       <= sp_dec;
                if (empty) begin
                    underflow <= 1'b1;
                end else begin
                    level <= level - 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_ret_stack.sv
// tb/tb_ret_stack.sv - self-checking bench for ret_stack with behavioural model
module tb_ret_stack;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] pc_in = '0;
    logic [WIDTH-1:0] ret_addr;
    logic             ret_valid;
    logic [3:0]       level;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int errors = 0;

    // Reference model: a ring of addresses indexed by a plain integer pointer.
    int m_mem [DEPTH];
    int m_sp, m_level, m_ret;
    bit m_valid, m_ovf, m_unf;

    ret_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .pc_in     (pc_in),
        .ret_addr  (ret_addr),
        .ret_valid (ret_valid),
        .level     (level),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        m_sp = 0; m_level = 0; m_ret = 0;
        m_valid = 0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic model_step(input bit p, input bit q, input int d);
        int top;
        top = (m_sp + DEPTH - 1) % DEPTH;
        m_valid = 0;
        if (p && q) begin
            m_ret = m_mem[top];
            m_mem[top] = d;
            m_valid = 1;
        end else if (p) begin
            if (m_level == DEPTH) begin
                m_ovf = 1;
`ifndef STACK_TRAP_EN
                m_mem[m_sp] = d;
                m_sp = (m_sp + 1) % DEPTH;
`endif
            end else begin
                m_mem[m_sp] = d;
                m_sp = (m_sp + 1) % DEPTH;
                m_level++;
            end
        end else if (q) begin
            m_valid = 1;
            if (m_level == 0) begin
                m_unf = 1;
`ifdef STACK_TRAP_EN
                m_ret = 0;
`else
                m_ret = m_mem[top];
                m_sp = top;
`endif
            end else begin
                m_ret = m_mem[top];
                m_sp = top;
                m_level--;
            end
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".ret_addr"},  int'(ret_addr),  m_ret);
        chk({tag, ".ret_valid"}, int'(ret_valid), int'(m_valid));
        chk({tag, ".level"},     int'(level),     m_level);
        chk({tag, ".overflow"},  int'(overflow),  int'(m_ovf));
        chk({tag, ".underflow"}, int'(underflow), int'(m_unf));
    endtask

    // Inputs change 1ns after a rising edge; outputs are sampled at the same point.
    task automatic step(input string tag, input bit p, input bit q, input logic [7:0] d);
        push = p; pop = q; pc_in = d;
        model_step(p, q, int'(d));
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0;
        chk_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        chk_all("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    int exp_ovf [DEPTH];

    initial begin
        model_reset();
        #3;
        chk_all("reset_init");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // single call / return
        step("single_push", 1, 0, 8'h05);
        chk("single_level1", int'(level), 1);
        step("single_pop", 0, 1, 8'h00);
        chk("single_ret", int'(ret_addr), 8'h05);
        chk("single_valid", int'(ret_valid), 1);
        chk("single_level0", int'(level), 0);
        step("single_idle", 0, 0, 8'h00);
        chk("single_pulse_end", int'(ret_valid), 0);
        chk("single_hold", int'(ret_addr), 8'h05);

        // nesting
        step("nest_push", 1, 0, 8'h10);
        step("nest_push", 1, 0, 8'h20);
        step("nest_push", 1, 0, 8'h30);
        chk("nest_level3", int'(level), 3);
        step("nest_pop", 0, 1, 8'h00);
        chk("nest_ret30", int'(ret_addr), 8'h30);
        step("nest_pop", 0, 1, 8'h00);
        chk("nest_ret20", int'(ret_addr), 8'h20);
        step("nest_pop", 0, 1, 8'h00);
        chk("nest_ret10", int'(ret_addr), 8'h10);
        chk("nest_level0", int'(level), 0);

        // overflow
        do_reset();
        for (int i = 1; i <= 9; i++) step("ovf_push", 1, 0, 8'(i));
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_level", int'(level), 8);
        for (int i = 0; i < DEPTH; i++) begin
`ifdef STACK_TRAP_EN
            exp_ovf[i] = 8 - i;
`else
            exp_ovf[i] = 9 - i;
`endif
        end
        for (int i = 0; i < DEPTH; i++) begin
            step("ovf_pop", 0, 1, 8'h00);
            chk("ovf_seq", int'(ret_addr), exp_ovf[i]);
        end
        chk("ovf_sticky", int'(overflow), 1);

        // simultaneous push + pop
        do_reset();
        step("sim_push", 1, 0, 8'h40);
        step("sim_both", 1, 1, 8'h41);
        chk("sim_ret40", int'(ret_addr), 8'h40);
        chk("sim_level1", int'(level), 1);
        chk("sim_no_flags", int'(overflow | underflow), 0);
        step("sim_pop", 0, 1, 8'h00);
        chk("sim_ret41", int'(ret_addr), 8'h41);

        // underflow
        step("unf_pop", 0, 1, 8'h00);
        chk("unf_flag", int'(underflow), 1);
        chk("unf_level", int'(level), 0);
`ifdef STACK_TRAP_EN
        chk("unf_zero", int'(ret_addr), 0);
`endif

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 45)      step("rnd", 1, 0, 8'($urandom));
            else if (r < 85) step("rnd", 0, 1, 8'($urandom));
            else if (r < 93) step("rnd", 1, 1, 8'($urandom));
            else             step("rnd", 0, 0, 8'($urandom));
            if (n % 500 == 499) do_reset();
        end

        // asynchronous reset mid-sequence with push held
        step("mid_push", 1, 0, 8'h77);
        step("mid_push", 1, 0, 8'h78);
        step("mid_pop", 0, 1, 8'h00);
        for (int i = 0; i < 10; i++) step("mid_fill", 1, 0, 8'(i));
        step("mid_pop2", 0, 1, 8'h00);
        chk("mid_pre_valid", int'(ret_valid), 1);
        push = 1'b1; pc_in = 8'h99;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_level", int'(level), 0);
        chk("mid_rst_valid", int'(ret_valid), 0);
        chk("mid_rst_ovf", int'(overflow), 0);
        chk("mid_rst_unf", int'(underflow), 0);
        chk("mid_rst_ret", int'(ret_addr), 0);
        @(posedge clk); #1;
        chk("mid_rst_held_level", int'(level), 0);
        push = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        step("post_pop", 0, 1, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
